// File: rtl/bubble_layer_mux_pkg.sv
// Shared types for bubble_layer_mux: pixel colour, transparency code,
// collision FSM states and the layer priority order.
package bubble_layer_mux_pkg;

  typedef logic [7:0] rgb_t;

  localparam rgb_t TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    ARMED,
    PENDING,
    COOLDOWN
  } collision_state_t;

  typedef enum logic [1:0] {
    LAYER_PLAYER,
    LAYER_BALL,
    LAYER_ROPE,
    LAYER_BG
  } layer_t;

  // Highest-priority layer currently requesting the pixel.
  function automatic layer_t top_layer(input logic player_req,
                                       input logic ball_req,
                                       input logic rope_req);
    layer_t sel;
    if (player_req)    sel = LAYER_PLAYER;
    else if (ball_req) sel = LAYER_BALL;
    else if (rope_req) sel = LAYER_ROPE;
    else               sel = LAYER_BG;
    return sel;
  endfunction

endpackage

// File: rtl/bubble_layer_mux_frame_collision_latch.sv
// Per-pair collision latch: remembers an overlap during a frame, reports it
// as a one-cycle pulse after the next startOfFrame, then mutes for a while.
module frame_collision_latch
  import bubble_layer_mux_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic overlap,
  output logic hitPulse
);

  localparam logic [3:0] LOAD = 4'(COOLDOWN_FRAMES);

  collision_state_t r_state, w_state_next;
  logic [3:0]       r_count, w_count_next;
  logic             r_hit, w_hit_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ARMED;
      r_count <= 4'd0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_hit   <= w_hit_next;
    end
  end

  // An overlap on the startOfFrame cycle belongs to the frame that is starting.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_hit_next   = 1'b0;
    case (r_state)
      ARMED: begin
        if (overlap) w_state_next = PENDING;
      end
      PENDING: begin
        if (startOfFrame) begin
          w_hit_next   = 1'b1;
          w_count_next = LOAD;
          if (LOAD == 4'd0) w_state_next = overlap ? PENDING : ARMED;
          else              w_state_next = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (r_count <= 4'd1) begin
            w_count_next = 4'd0;
            w_state_next = overlap ? PENDING : ARMED;
          end else begin
            w_count_next = r_count - 4'd1;
          end
        end
      end
      default: begin
        w_state_next = ARMED;
        w_count_next = 4'd0;
      end
    endcase
  end

  assign hitPulse = r_hit;

endmodule

// File: rtl/bubble_layer_mux.sv
// Layer compositor (player > ball > rope > background) with registered output.
// Collision pulses exist only when BUBBLE_COLLISION_DETECT_EN is defined.
module bubble_layer_mux
  import bubble_layer_mux_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 2,
  parameter rgb_t        BG_FALLBACK     = 8'h00
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playerDrawingRequest,
  input  logic [7:0] playerRGB,
  input  logic       ballDrawingRequest,
  input  logic [7:0] ballRGB,
  input  logic       ropeDrawingRequest,
  input  logic [7:0] ropeRGB,
  input  logic [7:0] backGroundRGB,
  output logic [7:0] RGBOut,
  output logic       ballPlayerHit,
  output logic       ballRopeHit
);

  rgb_t r_rgb, w_rgb_next, w_bg;

  assign w_bg = (backGroundRGB == TRANSPARENT_ENCODING) ? BG_FALLBACK : backGroundRGB;

  always_comb begin
    w_rgb_next = w_bg;
    case (top_layer(playerDrawingRequest, ballDrawingRequest, ropeDrawingRequest))
      LAYER_PLAYER: w_rgb_next = playerRGB;
      LAYER_BALL:   w_rgb_next = ballRGB;
      LAYER_ROPE:   w_rgb_next = ropeRGB;
      default:      w_rgb_next = w_bg;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_rgb <= 8'h00;
    else         r_rgb <= w_rgb_next;
  end

  assign RGBOut = r_rgb;

`ifdef BUBBLE_COLLISION_DETECT_EN
  frame_collision_latch #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_ball_player (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .overlap     (ballDrawingRequest & playerDrawingRequest),
    .hitPulse    (ballPlayerHit)
  );

  frame_collision_latch #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_ball_rope (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .overlap     (ballDrawingRequest & ropeDrawingRequest),
    .hitPulse    (ballRopeHit)
  );
`else
  logic w_unused_collision;
  assign w_unused_collision = ^{startOfFrame, 4'(COOLDOWN_FRAMES)};
  assign ballPlayerHit = 1'b0;
  assign ballRopeHit   = 1'b0;
`endif

endmodule

// File: tb/tb_bubble_layer_mux.sv
// Directed bench for bubble_layer_mux: priority, fallback, collision pulses,
// cooldown, frame-boundary overlap and mid-frame reset.
module tb_bubble_layer_mux;

`ifdef BUBBLE_COLLISION_DETECT_EN
  localparam logic EN = 1'b1;
`else
  localparam logic EN = 1'b0;
`endif

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       playerDrawingRequest;
  logic [7:0] playerRGB;
  logic       ballDrawingRequest;
  logic [7:0] ballRGB;
  logic       ropeDrawingRequest;
  logic [7:0] ropeRGB;
  logic [7:0] backGroundRGB;
  logic [7:0] RGBOut;
  logic       ballPlayerHit;
  logic       ballRopeHit;

  int tests_run;
  int tests_failed;

  bubble_layer_mux #(
    .COOLDOWN_FRAMES(2),
    .BG_FALLBACK    (8'h3C)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .playerDrawingRequest(playerDrawingRequest),
    .playerRGB           (playerRGB),
    .ballDrawingRequest  (ballDrawingRequest),
    .ballRGB             (ballRGB),
    .ropeDrawingRequest  (ropeDrawingRequest),
    .ropeRGB             (ropeRGB),
    .backGroundRGB       (backGroundRGB),
    .RGBOut              (RGBOut),
    .ballPlayerHit       (ballPlayerHit),
    .ballRopeHit         (ballRopeHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    playerDrawingRequest = 1'b0;
    ballDrawingRequest   = 1'b0;
    ropeDrawingRequest   = 1'b0;
    startOfFrame         = 1'b0;
    resetN               = 1'b0;
    #1;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  initial begin
    tests_run            = 0;
    tests_failed         = 0;
    resetN               = 1'b0;
    startOfFrame         = 1'b0;
    playerDrawingRequest = 1'b0;
    ballDrawingRequest   = 1'b0;
    ropeDrawingRequest   = 1'b0;
    playerRGB            = 8'h1C;
    ballRGB              = 8'hD4;
    ropeRGB              = 8'h33;
    backGroundRGB        = 8'h92;

    #2;
    chk8("reset_rgb", RGBOut, 8'h00);
    chk1("reset_bp", ballPlayerHit, 1'b0);
    chk1("reset_br", ballRopeHit, 1'b0);
    tick();
    tick();
    resetN = 1'b1;

    // Priority and background handling
    playerDrawingRequest = 1'b1; ballDrawingRequest = 1'b1;
    tick(); chk8("player_over_ball", RGBOut, 8'h1C);
    chk1("no_hit_before_first_sof", ballPlayerHit, 1'b0);
    playerDrawingRequest = 1'b0;
    tick(); chk8("ball_only", RGBOut, 8'hD4);
    ballDrawingRequest = 1'b0;
    tick(); chk8("background", RGBOut, 8'h92);
    ropeDrawingRequest = 1'b1;
    tick(); chk8("rope_only", RGBOut, 8'h33);
    ballDrawingRequest = 1'b1;
    tick(); chk8("ball_over_rope", RGBOut, 8'hD4);
    playerDrawingRequest = 1'b1;
    tick(); chk8("player_over_all", RGBOut, 8'h1C);
    playerDrawingRequest = 1'b0; ballDrawingRequest = 1'b0; ropeDrawingRequest = 1'b0;
    backGroundRGB = 8'hFF;
    tick(); chk8("bg_fallback", RGBOut, 8'h3C);
    ropeDrawingRequest = 1'b1;
    tick(); chk8("rope_over_transparent_bg", RGBOut, 8'h33);
    ropeDrawingRequest = 1'b0; backGroundRGB = 8'h92;
    tick();
    chk1("idle_bp_before_sof", ballPlayerHit, 1'b0);
    chk1("idle_br_before_sof", ballRopeHit, 1'b0);
    $display("[TB] priority checks done at %0t", $time);

    // Both pairs overlapped above: both pulse together on the first SOF
    pulse_sof();
    chk1("both_pairs_bp", ballPlayerHit, EN);
    chk1("both_pairs_br", ballRopeHit, EN);
    tick();
    chk1("pulse_one_cycle_bp", ballPlayerHit, 1'b0);
    chk1("pulse_one_cycle_br", ballRopeHit, 1'b0);
    $display("[TB] simultaneous pulse check done at %0t", $time);

    // 50 overlapping pixels in frame N, then cooldown across frames 2..4
    do_reset();
    pulse_sof();
    chk1("frameN_sof_bp", ballPlayerHit, 1'b0);
    tick(); tick();
    playerDrawingRequest = 1'b1; ballDrawingRequest = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk1("inframe_bp", ballPlayerHit, 1'b0);
      chk1("inframe_br", ballRopeHit, 1'b0);
    end
    playerDrawingRequest = 1'b0; ballDrawingRequest = 1'b0;
    tick(); tick(); tick();
    pulse_sof();
    chk1("frame1_bp", ballPlayerHit, EN);
    chk1("frame1_br", ballRopeHit, 1'b0);
    tick();
    chk1("frame1_bp_end", ballPlayerHit, 1'b0);
    $display("[TB] 50-pixel frame check done at %0t", $time);
    for (int f = 2; f <= 4; f++) begin
      tick();
      playerDrawingRequest = 1'b1; ballDrawingRequest = 1'b1;
      repeat (5) tick();
      playerDrawingRequest = 1'b0; ballDrawingRequest = 1'b0;
      tick(); tick();
      pulse_sof();
      chk1($sformatf("cooldown_frame%0d_bp", f), ballPlayerHit, (f == 4) ? EN : 1'b0);
      chk1($sformatf("cooldown_frame%0d_br", f), ballRopeHit, 1'b0);
      $display("[TB] cooldown frame %0d bp=%b", f, ballPlayerHit);
    end

    // Overlap coincident with startOfFrame belongs to the new frame
    do_reset();
    pulse_sof();
    chk1("coinc_first_sof", ballPlayerHit, 1'b0);
    tick(); tick(); tick();
    playerDrawingRequest = 1'b1; ballDrawingRequest = 1'b1; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0; playerDrawingRequest = 1'b0; ballDrawingRequest = 1'b0;
    chk1("coinc_no_pulse", ballPlayerHit, 1'b0);
    repeat (4) tick();
    chk1("coinc_quiet", ballPlayerHit, 1'b0);
    pulse_sof();
    chk1("coinc_next_sof", ballPlayerHit, EN);
    $display("[TB] coincident overlap check done at %0t", $time);

    // Reset mid-frame discards the pending overlap
    do_reset();
    pulse_sof();
    playerDrawingRequest = 1'b1; ballDrawingRequest = 1'b1;
    tick(); tick(); tick();
    resetN = 1'b0;
    #1;
    chk8("rgb_async_reset", RGBOut, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("rgb_held_in_reset", RGBOut, 8'h00);
    end
    resetN = 1'b1;
    playerDrawingRequest = 1'b0; ballDrawingRequest = 1'b0;
    tick();
    chk8("rgb_after_reset", RGBOut, 8'h92);
    pulse_sof();
    chk1("no_pulse_after_reset_1", ballPlayerHit, 1'b0);
    repeat (3) tick();
    pulse_sof();
    chk1("no_pulse_after_reset_2", ballPlayerHit, 1'b0);
    chk1("no_pulse_after_reset_br", ballRopeHit, 1'b0);
    $display("[TB] mid-frame reset check done at %0t", $time);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
